line_writeback: RTL and testbench
=================================

# line_writeback

Write-back adapter for the data-side L1 path: accepts one whole cache line plus its base address and drains it to main memory one 32-bit word at a time on the data write port. It is the write-direction counterpart of the line-fill adapter. The fill adapter gathers memory words into a line; this block scatters a line back out as word writes. It sits between the data cache controller (line side) and the main memory data port (word side).

## Interface
Parameters:
- WORDS_PER_LINE, 8, words per line; power of two, ≥2
- WORD_SIZE, 32, bits per word; fixed at 32 for main memory

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- wb_req  in  1  line write-back request; sampled only when wb_ready=1
- wb_addr  in  32  line address; low log2(WORDS_PER_LINE)+2 bits are ignored and treated as 0
- wb_line  in  WORDS_PER_LINE*32  line data; word 0 = bits [31:0]
- wb_ready  out  1  idle, able to accept a request
- wb_done  out  1  one-cycle pulse; last word acknowledged by memory
- mem_we  out  1  word write strobe to main memory
- mem_addr  out  32  byte address of the current word
- mem_din  out  32  current word data
- mem_size  out  2  constant 2 (word)
- mem_valid  in  1  memory write acknowledge for the current word
- mem_restart  out  1  one-cycle pulse that re-arms the memory delay counter between words

## Operation
- Reset values: wb_ready=1, wb_done=0, mem_we=0, mem_addr=0, mem_din=0, mem_restart=0, mem_size=2. State is IDLE and the word index is 0.
- States: IDLE, WRITE, GAP, DONE.
- IDLE: wb_ready=1. On wb_req=1, register wb_line into the internal buffer, register the aligned base, set idx to the first word to write (0), and go to WRITE. The inputs may change after the accept edge.
- WRITE: mem_we=1, mem_addr = base + idx*4, mem_din = buf[idx]. Hold all three stable until mem_valid=1.
  - On mem_valid with a word remaining: advance idx and go to GAP.
  - On mem_valid with the last word: go to DONE.
- GAP: mem_we=0, mem_restart=1 for exactly one cycle, then go to WRITE.
- DONE: wb_done=1 for one cycle, then go to IDLE. wb_ready=0 in DONE.
- Ignored inputs:
  - wb_req outside IDLE is ignored. The block does not queue requests; the requester must hold wb_req until it sees wb_ready.
  - mem_valid outside WRITE is ignored.
- Address arithmetic: 32-bit. The base is aligned, so word offsets never carry into the line-address bits.
- Reset mid-operation aborts the transfer. Outputs return to their reset values on the next cycle, no wb_done is produced, and the partially written line is the requester's concern.

## Timing
- Acceptance is the rising edge with state=IDLE and wb_req=1. The word-0 write is presented on the cycle after that edge.
- With a zero-wait memory (mem_valid in the first WRITE cycle), word k is presented in cycle 2k after acceptance.
- wb_done is high in cycle 2*WORDS_PER_LINE-1; for 8 words that is cycle 15. wb_ready returns in cycle 2*WORDS_PER_LINE.
- Each memory wait cycle extends the current WRITE by one cycle.
- Back-to-back requests have a minimum spacing of 2*WORDS_PER_LINE+1 cycles between acceptances.
- No combinational path from wb_req to the mem_* outputs. mem_valid affects only next-state.

## Configuration
- LINE_WB_DIRTY_MASK_EN defined:
  - Adds port wb_dirty, input, WORDS_PER_LINE bits, captured with the line.
  - Only words with a set mask bit are written, in ascending index order. Clean words cost no cycles.
  - From WRITE, after the last dirty word is acknowledged, go straight to DONE.
  - A request with an all-zero mask goes IDLE→DONE, with wb_done on the cycle after acceptance and no mem_we.
- Not defined: the wb_dirty port is absent and every word is written.

## Test plan
- Zero-wait memory, wb_addr=0x0000_1234, line words 0x1000+k → eight writes to 0x1220, 0x1224, …, 0x123C with data 0x1000…0x1007. Exactly seven mem_restart pulses. wb_done in cycle 15; wb_ready in cycle 16.
- Memory holds mem_valid low for 3 cycles on each word → mem_addr, mem_din and mem_we stay stable across the wait. wb_done in cycle 15+8*3=39.
- wb_req held high throughout, with new data presented during the transfer → second line accepted only in the cycle wb_ready=1. The first line is unaffected by the new data.
- reset asserted during the word-3 WRITE → the next cycle shows mem_we=0, wb_ready=1 and no wb_done. A new request completes normally.
- Stray mem_valid pulses in IDLE and GAP → no state or index change.
- With LINE_WB_DIRTY_MASK_EN:
  - Mask 0b1000_0101 → writes only to words 0, 2 and 7, with exactly two mem_restart pulses.
  - Mask 0 → wb_done on the cycle after acceptance, with mem_we never asserted.

Source files
------------

// File: rtl/line_writeback.sv
// Cache-line write-back adapter: captures a whole line and drains it to memory one word per WRITE.
// Optional feature LINE_WB_DIRTY_MASK_EN adds a per-word dirty mask; clean words are skipped.
module line_writeback #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_SIZE      = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wb_req,
  input  logic [31:0]                         wb_addr,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] wb_line,
`ifdef LINE_WB_DIRTY_MASK_EN
  input  logic [WORDS_PER_LINE-1:0]           wb_dirty,
`endif
  output logic                                wb_ready,
  output logic                                wb_done,
  output logic                                mem_we,
  output logic [31:0]                         mem_addr,
  output logic [WORD_SIZE-1:0]                mem_din,
  output logic [1:0]                          mem_size,
  input  logic                                mem_valid,
  output logic                                mem_restart
);

  localparam int unsigned IW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF = IW + 2;
  localparam logic [31:0] ALIGN_MASK = ~32'(WORDS_PER_LINE * 4 - 1);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  state_t                               state_q, state_d;
  logic [IW-1:0]                        idx_q;
  logic [31:0]                          base_q;
  logic [WORDS_PER_LINE*WORD_SIZE-1:0]  line_q;

  logic          start_any;
  logic [IW-1:0] start_idx;
  logic          more;
  logic [IW-1:0] next_idx;

`ifdef LINE_WB_DIRTY_MASK_EN
  logic [WORDS_PER_LINE-1:0] dirty_q;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    start_any = 1'b0;
    start_idx = '0;
    more      = 1'b0;
    next_idx  = '0;
    for (int unsigned i = WORDS_PER_LINE; i > 0; i--) begin
      if (wb_dirty[i-1]) begin
        start_any = 1'b1;
        start_idx = IW'(i - 1);
      end
      if (dirty_q[i-1] && ((i - 1) > 32'(idx_q))) begin
        more     = 1'b1;
        next_idx = IW'(i - 1);
      end
    end
  end
`else
  always_comb begin
    start_any = 1'b1;
    start_idx = '0;
    more      = (idx_q != IW'(WORDS_PER_LINE - 1));
    next_idx  = idx_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
`ifdef LINE_WB_DIRTY_MASK_EN
      dirty_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && wb_req) begin
        line_q  <= wb_line;
        base_q  <= wb_addr & ALIGN_MASK;
        idx_q   <= start_idx;
`ifdef LINE_WB_DIRTY_MASK_EN
        dirty_q <= wb_dirty;
`endif
      end else if (state_q == WRITE && mem_valid && more) begin
        idx_q <= next_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wb_ready    = 1'b0;
    wb_done     = 1'b0;
    mem_we      = 1'b0;
    mem_restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        wb_ready = 1'b1;
        if (wb_req) state_d = start_any ? WRITE : DONE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_valid) state_d = more ? GAP : DONE;
      end
      GAP: begin
        mem_restart = 1'b1;
        state_d     = WRITE;
      end
      DONE: begin
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data come straight from registers, so wb_req never reaches mem_* combinationally.
  assign mem_addr = base_q + {{(32 - OFF){1'b0}}, idx_q, 2'b00};
  assign mem_din  = line_q[idx_q*WORD_SIZE +: WORD_SIZE];
  assign mem_size = 2'd2;

endmodule

// File: tb/tb_line_writeback.sv
// Scoreboard bench for line_writeback: randomized lines and memory wait states against a word-list model.
`timescale 1ns/1ps
module tb_line_writeback;
  localparam int N  = 8;
  localparam int LW = N * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wb_req = 1'b0;
  logic [31:0]   wb_addr = '0;
  logic [LW-1:0] wb_line = '0;
  logic [N-1:0]  wb_dirty = '1;
  logic          wb_ready, wb_done, mem_we, mem_restart;
  logic [31:0]   mem_addr, mem_din;
  logic [1:0]    mem_size;
  logic          mem_valid = 1'b0;

  line_writeback #(.WORDS_PER_LINE(N), .WORD_SIZE(32)) dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
`ifdef LINE_WB_DIRTY_MASK_EN
    .wb_dirty(wb_dirty),
`endif
    .wb_ready(wb_ready), .wb_done(wb_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_size(mem_size), .mem_valid(mem_valid), .mem_restart(mem_restart)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int unsigned acc_cyc; int unsigned nw; int unsigned wait0; } ln_t;

  wr_t wq[$];
  ln_t lq[$];

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned cyc = 0, n_acc = 0, wait_acc = 0, popped = 0, rcount = 0;
  int unsigned mem_mode = 0, wl = 0;
  bit stray_en = 1'b0, prev_done = 1'b0, prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [N-1:0] rand_mask();
`ifdef LINE_WB_DIRTY_MASK_EN
    return N'($urandom);
`else
    return '1;
`endif
  endfunction

  // Reference: the line is a list of (address, word) writes in ascending index order.
  task automatic predict(input logic [31:0] a, input logic [LW-1:0] l, input logic [N-1:0] m);
    logic [31:0]   base;
    logic [LW-1:0] lv;
    wr_t           w;
    ln_t           ln;
    base  = a - (a % (N * 4));
    ln.nw = 0;
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        lv     = l >> (32 * k);
        w.addr = base + 32'(4 * k);
        w.data = lv[31:0];
        wq.push_back(w);
        ln.nw++;
      end
    end
    ln.acc_cyc = cyc + 1;
    ln.wait0   = wait_acc;
    lq.push_back(ln);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: wait states per word, optional stray acknowledges outside WRITE.
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      if (!prev_we) wl = (mem_mode == 0) ? 0 : (mem_mode == 1) ? 3 : $urandom_range(0, 3);
      if (wl == 0) mem_valid = 1'b1;
      else begin
        mem_valid = 1'b0;
        wl--;
        wait_acc++;
      end
    end else begin
      mem_valid = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    prev_we = mem_we;
  end

  // Monitor: compares presented writes against the queue head, closes lines on wb_done.
  always @(negedge clk) begin
    ln_t ln;
    int unsigned exp_done;
    if (reset) begin
      wq.delete();
      lq.delete();
      rcount    = 0;
      popped    = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("ready_after_done", 32'(wb_ready), 32'(1));
      prev_done = wb_done;
      if (mem_we) begin
        if (wq.size() == 0) check("spurious_write", 32'(mem_we), 32'(0));
        else begin
          check("mem_addr", mem_addr, wq[0].addr);
          check("mem_din", mem_din, wq[0].data);
          check("mem_size", 32'(mem_size), 32'(2));
          if (mem_valid) begin
            void'(wq.pop_front());
            popped++;
          end
        end
      end
      if (mem_restart) begin
        rcount++;
        check("restart_without_we", 32'(mem_we), 32'(0));
      end
      if (wb_done) begin
        if (lq.size() == 0) check("spurious_done", 32'(wb_done), 32'(0));
        else begin
          ln = lq.pop_front();
          exp_done = ln.acc_cyc + ((ln.nw == 0) ? 0 : 2 * ln.nw - 1) + (wait_acc - ln.wait0);
          check("writes_left_at_done", 32'(wq.size()), 32'(0));
          check("done_cycle", cyc, exp_done);
          check("restart_count", rcount, (ln.nw == 0) ? 0 : ln.nw - 1);
          check("ready_in_done", 32'(wb_ready), 32'(0));
        end
        rcount = 0;
        popped = 0;
      end
      if (wb_ready && wb_req) begin
        predict(wb_addr, wb_line, wb_dirty);
        n_acc++;
      end
    end
  end

  // Presents a request (from posedge+1 timing) and returns just after the accepting edge; wb_req stays high.
  task automatic send(input logic [31:0] a, input logic [LW-1:0] l, input logic [N-1:0] m, input bit scramble);
    int unsigned start, t;
    start    = n_acc;
    t        = 0;
    wb_req   = 1'b1;
    wb_addr  = a;
    wb_line  = l;
    wb_dirty = m;
    while (n_acc == start && t < 500) begin
      @(posedge clk); #1;
      t++;
      if (n_acc == start && scramble) begin
        wb_line = rand_line();
        wb_addr = $urandom;
      end
    end
    check("accepted", n_acc - start, 32'(1));
    wb_addr = $urandom;
    wb_line = rand_line();
  endtask

  task automatic wait_idle();
    int unsigned t;
    t = 0;
    while ((lq.size() != 0 || !wb_ready) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(lq.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] l;
    int unsigned t;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(wb_ready), 32'(1));
    check("rst_done", 32'(wb_done), 32'(0));
    check("rst_we", 32'(mem_we), 32'(0));
    check("rst_addr", mem_addr, 32'h0);
    check("rst_din", mem_din, 32'h0);
    check("rst_restart", 32'(mem_restart), 32'(0));
    check("rst_size", 32'(mem_size), 32'(2));
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait directed line: words 0x1000+k to 0x1220..0x123C.
    mem_mode = 0;
    for (int k = 0; k < N; k++) l[32*k +: 32] = 32'h1000 + 32'(k);
    send(32'h0000_1234, l, '1, 1'b0);
    wb_req = 1'b0;
    wait_idle();

    // Three wait cycles per word.
    mem_mode = 1;
    send($urandom, rand_line(), '1, 1'b0);
    wb_req = 1'b0;
    wait_idle();

    // wb_req held high with changing data while the first line drains.
    mem_mode = 2;
    send($urandom, rand_line(), '1, 1'b0);
    send($urandom, rand_line(), '1, 1'b1);
    wb_req = 1'b0;
    wait_idle();

    // Stray acknowledges in IDLE, GAP and DONE.
    stray_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send($urandom, rand_line(), '1, 1'b0);
      wb_req = 1'b0;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      wait_idle();
    end
    stray_en = 1'b0;

    // Reset during the word-3 WRITE aborts without wb_done.
    mem_mode = 2;
    send($urandom, rand_line(), '1, 1'b0);
    wb_req = 1'b0;
    t = 0;
    while (t < 500) begin
      @(negedge clk); #1;
      t++;
      if (popped == 3 && mem_we) break;
    end
    check("reached_word3", popped, 32'(3));
    reset = 1'b1;
    @(negedge clk); #1;
    check("abort_we", 32'(mem_we), 32'(0));
    check("abort_ready", 32'(wb_ready), 32'(1));
    check("abort_done", 32'(wb_done), 32'(0));
    check("abort_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send($urandom, rand_line(), '1, 1'b0);
    wb_req = 1'b0;
    wait_idle();

`ifdef LINE_WB_DIRTY_MASK_EN
    mem_mode = 0;
    send($urandom, rand_line(), 8'b1000_0101, 1'b0);
    wb_req = 1'b0;
    wait_idle();
    send($urandom, rand_line(), '0, 1'b0);
    wb_req = 1'b0;
    wait_idle();
`endif

    // Randomized mix.
    for (int i = 0; i < 12; i++) begin
      mem_mode = $urandom_range(0, 2);
      stray_en = 1'($urandom_range(0, 1));
      send($urandom, rand_line(), rand_mask(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) wb_req = 1'b0;
    end
    wb_req = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
